// File: rtl/tcdm_arb_pkg.sv
// Shared types and helpers for the TCDM round-robin arbiter slice.
package tcdm_arb_pkg;

  localparam int unsigned DefaultNr = 4;

  typedef logic [$clog2(DefaultNr)-1:0] id_t;

  // Next round-robin position after ptr, wrapping n-1 back to 0.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/tcdm_rr_arbiter_if.sv
// Bundle of the requester-side and memory-side TCDM channels around the arbiter.
interface tcdm_rr_arbiter_if #(
  parameter int unsigned NR = 4,
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic [NR-1:0]                in_req_i;
  logic [NR-1:0]                in_gnt_o;
  logic [NR-1:0][AW-1:0]        in_add_i;
  logic [NR-1:0]                in_wen_i;
  logic [NR-1:0][DW/8-1:0]      in_be_i;
  logic [NR-1:0][DW-1:0]        in_data_i;
  logic [NR-1:0][DW-1:0]        in_r_data_o;
  logic [NR-1:0]                in_r_valid_o;
  logic                         out_req_o;
  logic                         out_gnt_i;
  logic [AW-1:0]                out_add_o;
  logic                         out_wen_o;
  logic [DW/8-1:0]              out_be_o;
  logic [DW-1:0]                out_data_o;
  logic [DW-1:0]                out_r_data_i;
  logic                         out_r_valid_i;

  // The arbiter itself sees the bundle from this side.
  modport slave (
    input  in_req_i, in_add_i, in_wen_i, in_be_i, in_data_i,
    output in_gnt_o, in_r_data_o, in_r_valid_o,
    output out_req_o, out_add_o, out_wen_o, out_be_o, out_data_o,
    input  out_gnt_i, out_r_data_i, out_r_valid_i
  );

  modport master (
    output in_req_i, in_add_i, in_wen_i, in_be_i, in_data_i,
    input  in_gnt_o, in_r_data_o, in_r_valid_o,
    input  out_req_o, out_add_o, out_wen_o, out_be_o, out_data_o,
    output out_gnt_i, out_r_data_i, out_r_valid_i
  );

endinterface

// File: rtl/tcdm_arb_id_fifo.sv
// In-order FIFO of granted requester IDs; head is the owner of the next response.
module tcdm_arb_id_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  function automatic logic [PW-1:0] wrapInc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= wrapInc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= wrapInc(r_rptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/tcdm_rr_arbiter.sv
// Round-robin share of one TCDM memory port among NR requesters, with in-order
// response routing through an ID FIFO.
module tcdm_rr_arbiter
  import tcdm_arb_pkg::*;
#(
  parameter int unsigned NR              = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned AW              = 32,
  parameter int unsigned DW              = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  tcdm_rr_arbiter_if.slave   bus,
  output logic               err_o
);

  localparam int unsigned IDW = $clog2(NR);

  logic [IDW-1:0] r_ptr;
  logic           r_err;
  logic [IDW-1:0] w_win;
  logic [IDW-1:0] w_idx;
  logic [IDW-1:0] w_head;
  logic           w_any;
  logic           w_full;
  logic           w_empty;
  logic           w_hs;
  logic           w_pop;

  // First requester at or above the pointer, wrapping around.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      w_idx = IDW'((32'(r_ptr) + k) % NR);
      if (!w_any && bus.in_req_i[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  assign bus.out_req_o = w_any & ~w_full;
  assign w_hs          = bus.out_req_o & bus.out_gnt_i;
  assign w_pop         = bus.out_r_valid_i & ~w_empty;
  assign err_o         = r_err;

  always_comb begin
    bus.out_add_o  = '0;
    bus.out_wen_o  = 1'b0;
    bus.out_be_o   = '0;
    bus.out_data_o = '0;
    bus.in_gnt_o   = '0;
    if (bus.out_req_o) begin
      bus.out_add_o  = bus.in_add_i[w_win];
      bus.out_wen_o  = bus.in_wen_i[w_win];
      bus.out_be_o   = bus.in_be_i[w_win];
      bus.out_data_o = bus.in_data_i[w_win];
    end
    if (w_hs) begin
      bus.in_gnt_o[w_win] = 1'b1;
    end
  end

  // Responses go only to the FIFO head; everyone else sees zeros.
  always_comb begin
    bus.in_r_valid_o = '0;
    bus.in_r_data_o  = '0;
    if (w_pop) begin
      bus.in_r_valid_o[w_head] = 1'b1;
      bus.in_r_data_o[w_head]  = bus.out_r_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_hs) begin
        r_ptr <= IDW'(rr_next(32'(w_win), NR));
      end
      if (bus.out_r_valid_i && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  tcdm_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (IDW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_hs),
    .i_pop   (w_pop),
    .i_data  (w_win),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_tcdm_rr_arbiter.sv
// Self-checking bench for tcdm_rr_arbiter: arbitration vector table, directed
// corner sequences and randomized traffic against a queue-based reference model.
module tb_tcdm_rr_arbiter;

  localparam int unsigned NR   = 4;
  localparam int unsigned MAXO = 2;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;

  typedef struct {
    logic [NR-1:0] req;
    logic          gnt;
    logic          rv;
    logic [NR-1:0] expGnt;
    logic          expOutReq;
    logic [NR-1:0] expRValid;
  } vec_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rstN;
  logic errO;

  always #5 clk = ~clk;

  tcdm_rr_arbiter_if #(.NR(NR), .AW(AW), .DW(DW)) bus ();

  tcdm_rr_arbiter #(
    .NR              (NR),
    .MAX_OUTSTANDING (MAXO),
    .AW              (AW),
    .DW              (DW)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rstN),
    .bus    (bus),
    .err_o  (errO)
  );

  int total = 0;
  int bad   = 0;
  int cycleN = 0;

  // Requester agents: a pending transaction is held stable until granted.
  bit              reqValid [NR];
  logic [AW-1:0]   reqAdd   [NR];
  logic            reqWen   [NR];
  logic [DW/8-1:0] reqBe    [NR];
  logic [DW-1:0]   reqData  [NR];

  logic          memGnt;
  int            memLat;
  bit            memOn;
  logic          forceRv;
  logic [DW-1:0] forceRdata;
  logic [DW-1:0] memArr [64];
  resp_t         respQ [$];

  // Reference model state: pointer as an int, outstanding owners as a queue.
  int ptrM;
  int fifoM [$];
  bit errM;

  logic [NR-1:0]    lastGnt;
  logic [NR-1:0]    lastRValid;
  logic             lastOutReq;
  logic             lastErr;
  logic [NR*DW-1:0] lastRData;
  int               gntCycles [$];

  vec_t vecs [16];

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic resetModel();
    ptrM = 0;
    fifoM.delete();
    errM = 1'b0;
  endtask

  task automatic clearAgents();
    for (int i = 0; i < NR; i++) begin
      reqValid[i] = 1'b0;
    end
  endtask

  task automatic setReq(input int i, input logic [AW-1:0] a, input logic w,
                        input logic [DW/8-1:0] b, input logic [DW-1:0] d);
    reqValid[i] = 1'b1;
    reqAdd[i]   = a;
    reqWen[i]   = w;
    reqBe[i]    = b;
    reqData[i]  = d;
  endtask

  task automatic randomRefill();
    for (int i = 0; i < NR; i++) begin
      if (!reqValid[i] && $urandom_range(0, 1) == 1) begin
        setReq(i, ($urandom() & 32'hFFFF_FF00) | (32'($urandom_range(0, 63)) << 2),
               1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom());
      end
    end
  endtask

  // One clock cycle: drive, compare at negedge against the model, advance.
  task automatic applyStimulus();
    logic             rv;
    logic [DW-1:0]    rdata;
    int               win;
    int               head;
    int               mi;
    bit               hs;
    logic [NR-1:0]    eGnt;
    logic [NR-1:0]    eRv;
    logic             eReq;
    logic [AW-1:0]    eAdd;
    logic             eWen;
    logic [DW/8-1:0]  eBe;
    logic [DW-1:0]    eData;
    logic [NR*DW-1:0] eRdata;
    logic [DW-1:0]    mword;
    for (int i = 0; i < NR; i++) begin
      bus.in_req_i[i]  = reqValid[i];
      bus.in_add_i[i]  = reqAdd[i];
      bus.in_wen_i[i]  = reqWen[i];
      bus.in_be_i[i]   = reqBe[i];
      bus.in_data_i[i] = reqData[i];
    end
    bus.out_gnt_i = memGnt;
    rv    = forceRv;
    rdata = forceRdata;
    if (respQ.size() > 0 && respQ[0].due <= cycleN) begin
      rv    = 1'b1;
      rdata = respQ[0].data;
      respQ.delete(0);
    end
    bus.out_r_valid_i = rv;
    bus.out_r_data_i  = rdata;
    @(negedge clk);

    win = -1;
    for (int k = 0; k < NR; k++) begin
      if (win < 0 && reqValid[(ptrM + k) % NR]) win = (ptrM + k) % NR;
    end
    eReq  = (win >= 0) && (fifoM.size() < MAXO);
    eAdd  = '0;
    eWen  = 1'b0;
    eBe   = '0;
    eData = '0;
    if (eReq) begin
      eAdd  = reqAdd[win];
      eWen  = reqWen[win];
      eBe   = reqBe[win];
      eData = reqData[win];
    end
    hs   = eReq && memGnt;
    eGnt = '0;
    if (hs) eGnt[win] = 1'b1;
    eRv    = '0;
    eRdata = '0;
    if (rv && fifoM.size() > 0) begin
      head = fifoM[0];
      eRv[head] = 1'b1;
      eRdata[head*DW +: DW] = rdata;
    end

    checkOutput("in_gnt", 128'(bus.in_gnt_o), 128'(eGnt));
    checkOutput("out_req", 128'(bus.out_req_o), 128'(eReq));
    checkOutput("out_add", 128'(bus.out_add_o), 128'(eAdd));
    checkOutput("out_wen", 128'(bus.out_wen_o), 128'(eWen));
    checkOutput("out_be", 128'(bus.out_be_o), 128'(eBe));
    checkOutput("out_data", 128'(bus.out_data_o), 128'(eData));
    checkOutput("in_r_valid", 128'(bus.in_r_valid_o), 128'(eRv));
    checkOutput("in_r_data", 128'(bus.in_r_data_o), 128'(eRdata));
    checkOutput("err", 128'(errO), 128'(errM));

    lastGnt    = bus.in_gnt_o;
    lastOutReq = bus.out_req_o;
    lastRValid = bus.in_r_valid_o;
    lastRData  = bus.in_r_data_o;
    lastErr    = errO;
    if (bus.in_gnt_o != '0) gntCycles.push_back(cycleN);

    // Memory reacts to what the arbiter actually presents on its port.
    if (memOn && bus.out_req_o && bus.out_gnt_i) begin
      mi = int'(bus.out_add_o[7:2]);
      mword = '0;
      if (bus.out_wen_o) begin
        mword = memArr[mi];
      end else begin
        for (int b = 0; b < DW/8; b++) begin
          if (bus.out_be_o[b]) memArr[mi][8*b +: 8] = bus.out_data_o[8*b +: 8];
        end
      end
      respQ.push_back('{cycleN + memLat, mword});
    end

    if (rv) begin
      if (fifoM.size() > 0) fifoM.delete(0);
      else errM = 1'b1;
    end
    if (hs) begin
      fifoM.push_back(win);
      ptrM = (win + 1) % NR;
      reqValid[win] = 1'b0;
    end
    @(posedge clk);
    #1;
    cycleN++;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_gnt"}, 128'(bus.in_gnt_o), 128'(0));
    checkOutput({tag, "_out_req"}, 128'(bus.out_req_o), 128'(0));
    checkOutput({tag, "_out_add"}, 128'(bus.out_add_o), 128'(0));
    checkOutput({tag, "_out_be"}, 128'(bus.out_be_o), 128'(0));
    checkOutput({tag, "_r_valid"}, 128'(bus.in_r_valid_o), 128'(0));
    checkOutput({tag, "_r_data"}, 128'(bus.in_r_data_o), 128'(0));
    checkOutput({tag, "_err"}, 128'(errO), 128'(0));
  endtask

  task automatic zeroInputs();
    bus.in_req_i      = '0;
    bus.in_add_i      = '0;
    bus.in_wen_i      = '0;
    bus.in_be_i       = '0;
    bus.in_data_i     = '0;
    bus.out_gnt_i     = 1'b0;
    bus.out_r_valid_i = 1'b0;
    bus.out_r_data_i  = '0;
  endtask

  initial begin
    // req, out_gnt, r_valid, expected in_gnt, expected out_req, expected in_r_valid
    vecs[0]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 4'b0000};
    vecs[1]  = '{4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, 4'b0001};
    vecs[2]  = '{4'b1111, 1'b1, 1'b1, 4'b0100, 1'b1, 4'b0010};
    vecs[3]  = '{4'b1111, 1'b1, 1'b1, 4'b1000, 1'b1, 4'b0100};
    vecs[4]  = '{4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 4'b1000};
    vecs[5]  = '{4'b0100, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0001};
    vecs[6]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000};
    vecs[7]  = '{4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, 4'b0000};
    vecs[8]  = '{4'b1001, 1'b1, 1'b0, 4'b1000, 1'b1, 4'b0000};
    vecs[9]  = '{4'b1001, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000};
    vecs[10] = '{4'b1001, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0100};
    vecs[11] = '{4'b1001, 1'b1, 1'b1, 4'b0001, 1'b1, 4'b1000};
    vecs[12] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0001};
    vecs[13] = '{4'b0011, 1'b1, 1'b0, 4'b0010, 1'b1, 4'b0000};
    vecs[14] = '{4'b0011, 1'b1, 1'b1, 4'b0001, 1'b1, 4'b0010};
    vecs[15] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0001};

    for (int i = 0; i < 64; i++) memArr[i] = $urandom();
    clearAgents();
    for (int i = 0; i < NR; i++) setReq(i, '0, 1'b1, '0, '0);
    clearAgents();
    memGnt = 1'b0; memLat = 1; memOn = 1'b0; forceRv = 1'b0; forceRdata = '0;
    zeroInputs();
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rstN = 1'b1;
    resetModel();

    $display("[TB] arbitration vector table");
    for (int v = 0; v < 16; v++) begin
      for (int i = 0; i < NR; i++) begin
        reqValid[i] = vecs[v].req[i];
        reqAdd[i]   = 32'(32'h100 + 4 * i);
        reqWen[i]   = 1'b1;
        reqBe[i]    = 4'hF;
        reqData[i]  = $urandom();
      end
      memGnt     = vecs[v].gnt;
      forceRv    = vecs[v].rv;
      forceRdata = $urandom();
      applyStimulus();
      checkOutput($sformatf("vec%0d_gnt", v), 128'(lastGnt), 128'(vecs[v].expGnt));
      checkOutput($sformatf("vec%0d_out_req", v), 128'(lastOutReq), 128'(vecs[v].expOutReq));
      checkOutput($sformatf("vec%0d_r_valid", v), 128'(lastRValid), 128'(vecs[v].expRValid));
    end
    forceRv = 1'b0;
    clearAgents();

    $display("[TB] single read, 1-cycle memory");
    memOn = 1'b1; memLat = 1; memGnt = 1'b1;
    memArr[4] = 32'hCAFE_0001;
    setReq(1, 32'h10, 1'b1, 4'hF, '0);
    applyStimulus();
    checkOutput("single_gnt", 128'(lastGnt), 128'(4'b0010));
    applyStimulus();
    checkOutput("single_r_valid", 128'(lastRValid), 128'(4'b0010));
    checkOutput("single_r_data", 128'(lastRData[63:32]), 128'(32'hCAFE_0001));

    $display("[TB] partial write then read-back");
    memArr[8] = 32'h1122_3344;
    setReq(2, 32'h20, 1'b0, 4'b0011, 32'hAAAA_5555);
    applyStimulus();
    applyStimulus();
    checkOutput("write_r_valid", 128'(lastRValid), 128'(4'b0100));
    setReq(2, 32'h20, 1'b1, 4'hF, '0);
    applyStimulus();
    applyStimulus();
    checkOutput("readback_data", 128'(lastRData[95:64]), 128'(32'h1122_5555));

    $display("[TB] 3-cycle memory with full ID FIFO");
    memLat = 3;
    gntCycles.delete();
    for (int i = 0; i < NR; i++) setReq(i, 32'(4 * i), 1'b1, 4'hF, '0);
    repeat (10) applyStimulus();
    if (gntCycles.size() >= 3) begin
      checkOutput("lat3_back_to_back", 128'(gntCycles[1] - gntCycles[0]), 128'(1));
      checkOutput("lat3_stall_gap", 128'(gntCycles[2] - gntCycles[1]), 128'(3));
    end else begin
      checkOutput("lat3_grant_count", 128'(gntCycles.size()), 128'(3));
    end

    $display("[TB] randomized traffic");
    for (int p = 0; p < 2; p++) begin
      memLat = (p == 0) ? 1 : 3;
      for (int c = 0; c < 300; c++) begin
        randomRefill();
        memGnt = ($urandom_range(0, 3) != 0);
        applyStimulus();
      end
      memGnt = 1'b1;
      repeat (25) applyStimulus();
    end

    $display("[TB] spurious response");
    forceRv = 1'b1; forceRdata = 32'hDEAD_BEEF;
    applyStimulus();
    forceRv = 1'b0;
    applyStimulus();
    checkOutput("err_set", 128'(lastErr), 128'(1));
    applyStimulus();
    checkOutput("err_held", 128'(lastErr), 128'(1));

    $display("[TB] reset with transactions outstanding");
    memLat = 3;
    for (int i = 0; i < NR; i++) setReq(i, 32'(4 * i), 1'b1, 4'hF, '0);
    repeat (2) applyStimulus();
    clearAgents();
    zeroInputs();
    rstN = 1'b0;
    #2;
    checkResetOutputs("mid_reset");
    @(posedge clk); cycleN++;
    @(posedge clk); cycleN++;
    #1;
    rstN = 1'b1;
    resetModel();
    for (int i = 0; i < NR; i++) setReq(i, 32'(4 * i + 64), 1'b1, 4'hF, '0);
    applyStimulus();
    checkOutput("post_reset_gnt", 128'(lastGnt), 128'(4'b0001));
    applyStimulus();
    checkOutput("late_response_err", 128'(lastErr), 128'(1));
    repeat (15) applyStimulus();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tcdm_rr_arbiter.md
Name: tcdm_rr_arbiter

Overview:
- Shares one TCDM slave port (e.g. the testbench dummy memory, or one bank) among NR TCDM requesters.
- Round-robin arbitration on the request channel.
- Tracks the requester ID of every granted transaction in an in-order ID FIFO and routes r_data/r_valid back to the owning requester.
- Sits between streamer/core TCDM masters and a single memory port; supports any fixed or variable response latency, provided responses arrive in order.

Parameters:
- NR, 4, number of requesters (>=2)
- MAX_OUTSTANDING, 2, depth of ID FIFO = max granted-but-unanswered transactions
- AW, 32, address width
- DW, 32, data width (BE width = DW/8)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- in_req_i  in  NR  per-requester request
- in_gnt_o  out  NR  per-requester grant
- in_add_i  in  NR x AW  addresses
- in_wen_i  in  NR  1=read, 0=write
- in_be_i  in  NR x DW/8  byte enables
- in_data_i  in  NR x DW  write data
- in_r_data_o  out  NR x DW  response data
- in_r_valid_o  out  NR  response valid
- out_req_o  out  1  request to memory
- out_gnt_i  in  1  memory grant
- out_add_o  out  AW  muxed address
- out_wen_o  out  1  muxed wen
- out_be_o  out  DW/8  muxed be
- out_data_o  out  DW  muxed write data
- out_r_data_i  in  DW  memory response data
- out_r_valid_i  in  1  memory response valid
- err_o  out  1  sticky protocol error (response with no outstanding ID)

Behaviour:
- Reset: rr pointer=0, FIFO empty, err_o=0; in_r_valid_o=0, in_r_data_o=0; all out_* driven 0 while no request.
- Winner: first requester with in_req_i set, scanning from rr pointer upward modulo NR. Combinational, same cycle.
- out_req_o = (|in_req_i) & ~fifo_full. out_add/wen/be/data_o = winner's fields when out_req_o=1, else 0.
- in_gnt_o[w] = out_req_o & out_gnt_i for the winner only; all other bits 0.
- Handshake (out_req_o & out_gnt_i): push winner ID into FIFO; rr pointer <= (winner+1) mod NR on next edge.
- No handshake: pointer unchanged. A stalled winner keeps priority, and its request must stay stable.
- Response (out_r_valid_i with FIFO non-empty): pop head ID h. Same cycle, combinational: in_r_valid_o[h]=1, in_r_data_o[h]=out_r_data_i; other requesters' valid=0, data=0. Writes also return r_valid, as the memory does.
- Response with FIFO empty: dropped; err_o set and held until reset.
- Full FIFO: out_req_o=0 even if a pop happens the same cycle (no bypass). Throughput at depth 2 with 1-cycle memory latency = 1 txn/cycle.
- Simultaneous push+pop on a non-full FIFO: both occur; occupancy unchanged.
- Pointer wrap: NR-1 -> 0.
- Reset mid-operation: FIFO flushed; any late responses after reset raise err_o.
- Occupancy counter width: $clog2(MAX_OUTSTANDING+1); read/write pointers wrap modulo MAX_OUTSTANDING.

Decomposition:
- Package tcdm_arb_pkg: typedef id_t = logic[$clog2(NR)-1:0]; function rr_next(ptr, NR).
- Sub-module tcdm_arb_id_fifo: ID FIFO with push/pop/full/empty/head. Synchronous, async reset, no fall-through.
- Top holds the rr pointer, winner search, request mux and response demux.

Test Plan:
- Single requester, 1-cycle memory, NR=4: req1 reads addr 0x10 holding 0xCAFE0001 -> in_gnt_o=4'b0010 same cycle; next cycle in_r_valid_o=4'b0010, in_r_data_o[1]=0xCAFE0001.
- All four requesting continuously, out_gnt_i=1 -> grant order 0,1,2,3,0; one grant per cycle; each response routed to its own issuer.
- Stalls: out_gnt_i low 2 cycles while req2 alone is pending -> in_gnt_o=0, pointer unchanged; grant on 3rd cycle; no response lost.
- Memory latency 3 cycles, MAX_OUTSTANDING=2: after 2 grants out_req_o=0 until the first r_valid. The next grant is the cycle after the pop.
- Write with be=4'b0011, data 0xAAAA5555 over 0x11223344 -> r_valid returned to issuer; read-back returns 0x11225555.
- Spurious out_r_valid_i with empty FIFO -> err_o=1 and held. Assert rst_ni mid-burst with 2 outstanding -> FIFO empty, err_o=0, pointer 0.
